// File: rtl/execute_stage_p_if.sv
// Bundle between the E pipeline register and the execute stage: E_* fields and
// downstream status in, e_* results and registered condition codes out.
interface execute_stage_p_if #(
    parameter int W = 64
);
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valC;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;

    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic         e_Cnd;
    logic [W-1:0] e_valE;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         e_busy;
    logic         cc_ZF;
    logic         cc_SF;
    logic         cc_OF;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, m_stat, W_stat,
        input  e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_busy, cc_ZF, cc_SF, cc_OF
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, m_stat, W_stat,
        output e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_busy, cc_ZF, cc_SF, cc_OF
    );
endinterface

// File: rtl/execute_stage_p.sv
// Y86 execute stage: ALU, registered condition codes, cmov/jump evaluation.
// Define EXEC_MUL_EN to build the iterative shift-add mulq unit (OPq ifun 4).
module execute_stage_p #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic              clk,
    input logic              rst,
    execute_stage_p_if.slave bus
);
    localparam logic [2:0]   STAT_AOK   = 3'd1;
    localparam logic [2:0]   STAT_INS   = 3'd4;
    localparam logic [3:0]   I_NOP      = 4'h1;
    localparam logic [3:0]   I_RRMOV    = 4'h2;
    localparam logic [3:0]   I_IRMOV    = 4'h3;
    localparam logic [3:0]   I_RMMOV    = 4'h4;
    localparam logic [3:0]   I_MRMOV    = 4'h5;
    localparam logic [3:0]   I_OPQ      = 4'h6;
    localparam logic [3:0]   I_JXX      = 4'h7;
    localparam logic [3:0]   I_CALL     = 4'h8;
    localparam logic [3:0]   I_RET      = 4'h9;
    localparam logic [3:0]   I_PUSH     = 4'hA;
    localparam logic [3:0]   I_POP      = 4'hB;
    localparam logic [W-1:0] STACK_STEP = W'(8);

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    cc_t          cc_q, cc_d;
    logic         busy;
    logic         stats_ok;
    logic [W-1:0] alu_r;
    logic         alu_of, op_ok;
    logic         uses_cc, cond_ok, cnd_raw, cnd, ins;

    assign stats_ok = (bus.E_stat == STAT_AOK) && (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

    mul_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic         mul_start, mul_abort;

    assign mul_start = !rst && (state_q == S_IDLE) && (bus.E_icode == I_OPQ) &&
                       (bus.E_ifun == 4'h4) && (bus.E_stat == STAT_AOK);
    assign mul_abort = (bus.m_stat != STAT_AOK) || (bus.W_stat != STAT_AOK);
    assign busy      = mul_start || (state_q == S_BUSY);

    // Bit 0 is consumed on the start edge, so BUSY only needs W-1 steps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            S_IDLE: if (mul_start) begin
                state_d  = S_BUSY;
                cnt_d    = '0;
                acc_d    = bus.E_valB[0] ? bus.E_valA : '0;
                mcand_d  = bus.E_valA << 1;
                mplier_d = bus.E_valB >> 1;
            end
            S_BUSY: if (mul_abort) begin
                state_d = S_IDLE;
            end else begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 2)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        alu_r  = '0;
        alu_of = 1'b0;
        op_ok  = 1'b0;
        case (bus.E_icode)
            I_RRMOV:          alu_r = bus.E_valA;
            I_IRMOV:          alu_r = bus.E_valC;
            I_RMMOV, I_MRMOV: alu_r = bus.E_valB + bus.E_valC;
            I_CALL, I_PUSH:   alu_r = bus.E_valB - STACK_STEP;
            I_RET, I_POP:     alu_r = bus.E_valB + STACK_STEP;
            I_OPQ: begin
                op_ok = 1'b1;
                case (bus.E_ifun)
                    4'h0: begin
                        alu_r  = bus.E_valB + bus.E_valA;
                        alu_of = (bus.E_valA[W-1] == bus.E_valB[W-1]) && (alu_r[W-1] != bus.E_valB[W-1]);
                    end
                    4'h1: begin
                        alu_r  = bus.E_valB - bus.E_valA;
                        alu_of = (bus.E_valA[W-1] != bus.E_valB[W-1]) && (alu_r[W-1] != bus.E_valB[W-1]);
                    end
                    4'h2: alu_r = bus.E_valB & bus.E_valA;
                    4'h3: alu_r = bus.E_valB ^ bus.E_valA;
`ifdef EXEC_MUL_EN
                    4'h4: alu_r = acc_q;
`endif
                    default: op_ok = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // Conditions read the registered flags, never the current ALU result.
    always_comb begin
        uses_cc = (bus.E_icode == I_RRMOV) || (bus.E_icode == I_JXX);
        cond_ok = bus.E_ifun <= 4'h6;
        cnd_raw = 1'b0;
        case (bus.E_ifun)
            4'h0: cnd_raw = 1'b1;
            4'h1: cnd_raw = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            4'h2: cnd_raw = cc_q.sf ^ cc_q.of;
            4'h3: cnd_raw = cc_q.zf;
            4'h4: cnd_raw = !cc_q.zf;
            4'h5: cnd_raw = !(cc_q.sf ^ cc_q.of);
            4'h6: cnd_raw = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
            default: cnd_raw = 1'b0;
        endcase
    end

    always_comb begin
        ins         = (uses_cc && !cond_ok) || ((bus.E_icode == I_OPQ) && !op_ok);
        cnd         = uses_cc && cond_ok && cnd_raw;
        bus.e_stat  = ins ? STAT_INS : bus.E_stat;
        bus.e_icode = bus.E_icode;
        bus.e_Cnd   = cnd;
        bus.e_valE  = alu_r;
        bus.e_valA  = bus.E_valA;
        bus.e_dstE  = ((bus.E_icode == I_RRMOV) && !cnd) ? RNONE : bus.E_dstE;
        bus.e_dstM  = bus.E_dstM;
        bus.e_busy  = busy;
        if (busy) begin
            bus.e_icode = I_NOP;
            bus.e_stat  = STAT_AOK;
            bus.e_Cnd   = 1'b0;
            bus.e_dstE  = RNONE;
            bus.e_dstM  = RNONE;
        end
    end

    always_comb begin
        cc_d = cc_q;
        if ((bus.E_icode == I_OPQ) && op_ok && stats_ok && !busy)
            cc_d = {(alu_r == '0), alu_r[W-1], alu_of};
    end

    assign bus.cc_ZF = cc_q.zf;
    assign bus.cc_SF = cc_q.sf;
    assign bus.cc_OF = cc_q.of;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its _d from before the edge.
        if (rst) begin
            cc_q     <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
`ifdef EXEC_MUL_EN
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            cc_q     <= cc_d;
`ifdef EXEC_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end
endmodule

// File: tb/tb_execute_stage_p.sv
// Scoreboard bench for execute_stage_p: a driver predicts each instruction with an
// arithmetic reference model; a monitor checks every presented result (mulq if EXEC_MUL_EN).
module tb_execute_stage_p;
    localparam int W = 64;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] INS = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_p_if #(.W(W)) bus ();
    execute_stage_p #(.W(W), .RNONE(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        bit           chk_valE;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic [2:0]   cc;
        int           busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   busy_run = 0;
    bit   mon_en   = 1'b0;
    bit   m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] vc, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] ms, input logic [2:0] ws);
        bus.E_stat = st;  bus.E_icode = ic; bus.E_ifun = fn;
        bus.E_valC = vc;  bus.E_valA  = va; bus.E_valB = vb;
        bus.E_dstE = de;  bus.E_dstM  = dm;
        bus.m_stat = ms;  bus.W_stat  = ws;
    endtask

    task automatic drive_nop();
        drive(AOK, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, AOK, AOK);
    endtask

    // Reference model: Y86 execute semantics in plain arithmetic, tracking CC as three bits.
    task automatic predict(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [W-1:0] vc, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [2:0] ms, input logic [2:0] ws, output exp_t e);
        logic [W:0]   wide;
        logic [W-1:0] r;
        bit ovf, opq_ok, cond_ic, bad, cnd, sxo, is_mul;
        r = '0; ovf = 0; cnd = 0;
        case (ic)
            4'h2: r = va;
            4'h3: r = vc;
            4'h4, 4'h5: r = vb + vc;
            4'h8, 4'hA: r = vb - 64'd8;
            4'h9, 4'hB: r = vb + 64'd8;
            4'h6: case (fn)
                4'h0: begin wide = {vb[W-1], vb} + {va[W-1], va}; r = wide[W-1:0]; ovf = wide[W] != wide[W-1]; end
                4'h1: begin wide = {vb[W-1], vb} - {va[W-1], va}; r = wide[W-1:0]; ovf = wide[W] != wide[W-1]; end
                4'h2: r = vb & va;
                4'h3: r = vb ^ va;
                4'h4: r = vb * va;
                default: ;
            endcase
            default: ;
        endcase
        is_mul  = (ic == 4'h6) && (fn == 4'h4) && MUL_EN;
        opq_ok  = (ic == 4'h6) && ((fn <= 4'h3) || is_mul);
        cond_ic = (ic == 4'h2) || (ic == 4'h7);
        bad     = (cond_ic && fn > 4'h6) || ((ic == 4'h6) && !opq_ok);
        sxo     = m_sf != m_of;
        if (cond_ic) begin
            case (fn)
                4'h0: cnd = 1;
                4'h1: cnd = sxo || m_zf;
                4'h2: cnd = sxo;
                4'h3: cnd = m_zf;
                4'h4: cnd = !m_zf;
                4'h5: cnd = !sxo;
                4'h6: cnd = !sxo && !m_zf;
                default: cnd = 0;
            endcase
        end
        e.stat     = bad ? INS : st;
        e.icode    = ic;
        e.cnd      = cnd;
        e.chk_valE = !bad && (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) &&
                     !(is_mul && st != AOK);
        e.valE     = r;
        e.valA     = va;
        e.dstE     = (ic == 4'h2 && !cnd) ? 4'hF : de;
        e.dstM     = dm;
        e.cc       = {m_zf, m_sf, m_of};
        e.busy     = (is_mul && st == AOK) ? W : 0;
        if (opq_ok && st == AOK && ms == AOK && ws == AOK) begin
            m_zf = (r == '0);
            m_sf = r[W-1];
            m_of = ovf;
        end
    endtask

    task automatic issue(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] vc, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] ms, input logic [2:0] ws, output int hold);
        exp_t e;
        drive(st, ic, fn, vc, va, vb, de, dm, ms, ws);
        predict(st, ic, fn, vc, va, vb, de, dm, ms, ws, e);
        sb_q.push_back(e);
        hold = e.busy + 1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return '1;
            default: return W'({$urandom(), $urandom()});
        endcase
    endfunction

    // Monitor: busy cycles must be bubbles; a non-busy cycle presents the next expected result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.e_busy) begin
                busy_run++;
                check("bubble", {bus.e_icode, bus.e_stat, bus.e_dstE, bus.e_dstM, bus.e_Cnd},
                      {4'h1, 3'd1, 4'hF, 4'hF, 1'b0});
            end else if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: result presented with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                check("e_stat",  bus.e_stat,  mon_e.stat);
                check("e_icode", bus.e_icode, mon_e.icode);
                check("e_Cnd",   bus.e_Cnd,   mon_e.cnd);
                check("e_valA",  bus.e_valA,  mon_e.valA);
                check("e_dstE",  bus.e_dstE,  mon_e.dstE);
                check("e_dstM",  bus.e_dstM,  mon_e.dstM);
                check("cc",      {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, mon_e.cc);
                check("busy_cycles", busy_run, mon_e.busy);
                if (mon_e.chk_valE) check("e_valE", bus.e_valE, mon_e.valE);
                busy_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        logic [3:0] ic, fn;
        logic [2:0] st, ms, ws;
        drive_nop();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cc",   {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, 3'b100);
        check("reset_busy", bus.e_busy, 1'b0);
        step(1);
        mon_en = 1'b1;

        issue(AOK, 4'h6, 4'h1, '0, 64'd5, 64'd3, 4'h2, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("subq_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        step(hold);
        issue(AOK, 4'h7, 4'h2, 64'h100, '0, '0, 4'hF, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("subq_cc", {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, 3'b010);
        check("jl_cnd",  bus.e_Cnd, 1'b1);
        step(hold);

        issue(AOK, 4'h6, 4'h0, '0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("addq_ovf_valE", bus.e_valE, 64'h8000_0000_0000_0000);
        step(hold);
        issue(AOK, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("addq_ovf_cc", {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, 3'b011);
        step(hold);
        issue(AOK, 4'h6, 4'h0, '0, 64'd1, 64'd1, 4'h3, 4'hF, 3'd3, AOK, hold);
        step(hold);
        issue(AOK, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("cc_suppressed", {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, 3'b011);
        step(hold);

        issue(AOK, 4'h6, 4'h0, '0, 64'd1, 64'd1, 4'h3, 4'hF, AOK, AOK, hold);
        step(hold);
        issue(AOK, 4'h2, 4'h1, '0, 64'd123, '0, 4'h3, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        check("cmovle_cnd",  bus.e_Cnd,  1'b0);
        check("cmovle_dstE", bus.e_dstE, 4'hF);
        step(hold);

        issue(AOK, 4'h6, 4'h4, '0, -64'sd3, 64'd7, 4'h5, 4'hF, AOK, AOK, hold);
        @(negedge clk);
        if (MUL_EN) begin
            check("mulq_busy_first", {bus.e_busy, bus.e_icode}, {1'b1, 4'h1});
            step(W);
            @(negedge clk);
            check("mulq_valE",      bus.e_valE, 64'hFFFF_FFFF_FFFF_FFEB);
            check("mulq_busy_done", bus.e_busy, 1'b0);
            step(1);
            issue(AOK, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, AOK, AOK, hold);
            @(negedge clk);
            check("mulq_cc_sf", bus.cc_SF, 1'b1);
            step(hold);
        end else begin
            check("mulq_off", {bus.e_stat, bus.e_busy}, {INS, 1'b0});
            step(hold);
        end

        for (int n = 0; n < 300; n++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h6)                     fn = 4'($urandom_range(0, 5));
            else if (ic == 4'h2 || ic == 4'h7)  fn = 4'($urandom_range(0, 7));
            else                                fn = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : AOK;
            ms = ($urandom_range(0, 7) == 0) ? 3'd3 : AOK;
            ws = ($urandom_range(0, 7) == 0) ? 3'd2 : AOK;
            if (ic == 4'h6 && fn == 4'h4) begin
                ms = AOK;
                ws = AOK;
            end
            issue(st, ic, fn, pick(), pick(), pick(), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ms, ws, hold);
            step(hold);
        end
        mon_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);

        // Reset during cycle 10 of a mulq.
        drive(AOK, 4'h6, 4'h1, '0, 64'd5, 64'd3, 4'h2, 4'hF, AOK, AOK);
        step(1);
        drive(AOK, 4'h6, 4'h4, '0, -64'sd3, 64'd7, 4'h5, 4'hF, AOK, AOK);
        step(9);
        @(negedge clk);
        check("busy_cycle10", bus.e_busy, MUL_EN);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        check("rst_abort_cc",   {bus.cc_ZF, bus.cc_SF, bus.cc_OF}, 3'b100);
        check("rst_abort_busy", bus.e_busy, 1'b0);
        step(1);

        if (MUL_EN) begin
            drive(AOK, 4'h6, 4'h4, '0, 64'd9, 64'd9, 4'h5, 4'hF, AOK, AOK);
            step(4);
            bus.m_stat = 3'd3;
            @(negedge clk);
            check("busy_before_abort", bus.e_busy, 1'b1);
            step(1);
            drive_nop();
            @(negedge clk);
            check("stat_abort_busy", bus.e_busy, 1'b0);
            step(W + 2);
            check("stat_abort_cc", {bus.cc_ZF, bus.cc_SF, bus.cc_OF, bus.e_busy}, 4'b1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_stage_p.md
# execute_stage_p

Parametrised Y86 pipeline execute stage with a registered condition-code (CC) register and an optional iterative multiplier. It sits between the E and M pipeline registers. Each cycle it evaluates ALU results, cmov/jump conditions and destination gating. It updates CC only when no exception is pending downstream, and it stalls upstream via `e_busy` during multi-cycle `mulq`.

## Interface
- `W`, 64: datapath width. Must be ≥16 and a multiple of 8.
- `RNONE`, 4'hF: register ID meaning "no destination".
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `E_stat` in 3: instruction status (AOK=1, HLT=2, ADR=3, INS=4).
- `E_icode`, `E_ifun` in 4 each: opcode and function.
- `E_valC`, `E_valA`, `E_valB` in W each: constant and operands.
- `E_dstE`, `E_dstM` in 4 each: destination register IDs.
- `m_stat`, `W_stat` in 3 each: status of the downstream stages.
- `e_stat`, `e_icode` out 3/4: forwarded status and icode.
- `e_Cnd` out 1: condition result.
- `e_valE`, `e_valA` out W each: ALU result and pass-through of valA.
- `e_dstE`, `e_dstM` out 4 each: gated destinations.
- `e_busy` out 1: stall request to pipeline control.
- `cc_ZF`, `cc_SF`, `cc_OF` out 1 each: registered condition codes.

## Operation
- **ALU operand select and result:**
  - rrmovq/cmovXX (2): 0 + valA.
  - irmovq (3): 0 + valC.
  - rmmovq/mrmovq (4/5): valB + valC.
  - OPq (6):
    - ifun 0: valB + valA.
    - ifun 1: valB − valA.
    - ifun 2: valB & valA.
    - ifun 3: valB ^ valA.
  - call/pushq (8/A): valB − 8.
  - ret/popq (9/B): valB + 8.
  - All arithmetic is modulo 2^W.
- **Flags:**
  - ZF = result==0.
  - SF = result[W-1].
  - OF = signed overflow for add/sub; 0 for and/xor.
- **CC update:** CC latches on the clock edge only when all of the following hold:
  - E_icode==6 with a valid ifun;
  - E_stat==AOK, m_stat==AOK and W_stat==AOK;
  - e_busy==0.
- **Cnd:** computed from the registered CC, never from the current result.
  - ifun 0: always 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - Applies to icodes 2 and 7. For all other icodes e_Cnd=0.
- **Destination gating:** icode 2 with Cnd=0 drives e_dstE=RNONE. Otherwise e_dstE=E_dstE and e_dstM=E_dstM.
- **Invalid ifun:** ifun>6 for icode 2/7, or OPq ifun outside the supported set, drives e_stat=INS. CC is not updated.
- **Pass-through:** otherwise e_stat=E_stat, e_icode=E_icode, e_valA=E_valA.
- **Multiplier FSM (only when compiled in):**
  - States IDLE, BUSY, DONE, with a counter `cnt` of log2(W) bits.
  - IDLE→BUSY when E_icode==6, ifun==4, E_stat==AOK. Operands are latched and cnt=0.
  - BUSY performs one shift-add step per cycle. Inputs on E_* are ignored while in BUSY.
  - BUSY→DONE after cnt reaches W−1.
  - DONE→IDLE after one cycle.
  - The result is the low W bits of valA*valB (two's complement, so correct for signed operands). ZF/SF follow from the result; OF=0.

## Timing
- Non-mul operations are combinational, with zero-cycle latency to `e_*`. CC is visible on the cycle after the operation.
- `mulq` timing:
  - `e_busy`=1 for exactly W cycles, starting in the cycle the instruction first appears in E (combinational in IDLE).
  - During those cycles the outputs present a bubble: e_icode=1 (nop), e_stat=AOK, e_dstE=e_dstM=RNONE, e_Cnd=0.
  - In DONE, `e_busy`=0 and e_valE holds the product with the held E fields. CC latches at the end of DONE, subject to the stat rule.
  - Total latency is W+1 cycles.
- Upstream must hold the E register while e_busy=1.
- If m_stat or W_stat becomes non-AOK during BUSY: the FSM aborts to IDLE on the next edge, the product is discarded, there is no CC update, and e_busy falls in the following cycle.
- **Reset values** (`rst` is synchronous, so state takes effect at the edge):
  - State IDLE, cnt=0.
  - ZF=1, SF=0, OF=0.
  - Product register cleared.
  - e_busy=0.
- Reset asserted during BUSY has the same effect.
- Combinational outputs follow the inputs during reset. CC is frozen at its reset values.

## Configuration
- `EXEC_MUL_EN` defined: OPq ifun 4 (`mulq`) is supported through the iterative FSM.
- `EXEC_MUL_EN` undefined: no FSM or product register is built, e_busy is tied to 0, and OPq ifun 4 yields e_stat=INS with no CC update.

## Test plan
- **Reset:** assert rst for 1 cycle → cc_ZF=1, cc_SF=0, cc_OF=0, e_busy=0.
- **subq then jl:** subq with valA=5, valB=3 → e_valE=0xFFFF_FFFF_FFFF_FFFE. Next cycle SF=1, ZF=0, OF=0. A following jl (7/2) gives e_Cnd=1.
- **Overflow and CC suppression:**
  - addq 0x7FFF_FFFF_FFFF_FFFF + 1 → e_valE=0x8000_0000_0000_0000; next cycle OF=1, SF=1.
  - Repeat with m_stat=3 → CC unchanged.
- **Failed cmov:** with CC Z=0, S=0, O=0, cmovle (2/1) with E_dstE=3 → e_Cnd=0, e_dstE=15.
- **mulq (EXEC_MUL_EN):** valA=−3, valB=7 → e_busy high for 64 cycles with e_icode=1. Cycle 65: e_valE=0xFFFF_FFFF_FFFF_FFEB, e_busy=0. Next cycle SF=1.
- **Abort and macro-off behaviour:**
  - rst in BUSY cycle 10 → IDLE and reset CC.
  - Macro off: mulq gives e_stat=4 with e_busy=0.
